// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback sequencer that owns the PC of the 8-puzzle solver core.
// Optional single-step mode (PAUSE between instructions) is enabled by defining PC_SEQUENCER_SINGLE_STEP_EN.
module pc_sequencer #(
   parameter int          PC_W      = 6,
   parameter logic [4:0]  HALT_OP   = 5'b11111,
   parameter logic [15:0] MAX_STEPS = 16'hFFFF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
   input  logic            step,
`endif
   output logic            busy,
   output logic            done,
   output logic            timeout,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [15:0]     imem_data,
   output logic [15:0]     op,
   output logic            zf,
   input  logic            alu_zf,
   input  logic [PC_W-1:0] dec_pc_in,
   input  logic            dec_pc_we,
   input  logic            dec_reg_we,
   input  logic            dec_mem_we,
   output logic            reg_we_o,
   output logic            mem_we_o,
   output logic [PC_W-1:0] pc,
   output logic [15:0]     steps
);

`ifdef PC_SEQUENCER_SINGLE_STEP_EN
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_DONE, S_PAUSE
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_DONE
   } state_t;
`endif

   state_t          state_reg, state_next;
   logic [PC_W-1:0] pc_reg;
   logic [15:0]     op_reg;
   logic            zf_reg;
   logic            pend_zf_reg;
   logic [15:0]     steps_reg;
   logic            timeout_reg;

   logic            is_halt;
   logic [15:0]     steps_inc;

   assign is_halt   = (op_reg[15:11] == HALT_OP);
   assign steps_inc = (steps_reg == 16'hFFFF) ? steps_reg : steps_reg + 16'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         pc_reg      <= '0;
         op_reg      <= '0;
         zf_reg      <= 1'b0;
         pend_zf_reg <= 1'b0;
         steps_reg   <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (start) begin
                  pc_reg      <= '0;
                  steps_reg   <= '0;
                  zf_reg      <= 1'b0;
                  timeout_reg <= 1'b0;
               end
            end
            S_FETCH: begin
               if (imem_ack) op_reg <= imem_data;
            end
            S_EXEC: pend_zf_reg <= alu_zf;
            S_WB: begin
               zf_reg    <= pend_zf_reg;
               steps_reg <= steps_inc;
               // A retiring HALT leaves the PC pointing at itself and never flags a timeout.
               if (!is_halt) begin
                  pc_reg <= dec_pc_we ? dec_pc_in : pc_reg + {{(PC_W-1){1'b0}}, 1'b1};
                  if (steps_inc == MAX_STEPS) timeout_reg <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      imem_req   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      reg_we_o   = 1'b0;
      mem_we_o   = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) state_next = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            busy     = 1'b1;
            if (imem_ack) state_next = S_DECODE;
         end
         S_DECODE: begin
            busy       = 1'b1;
            state_next = S_EXEC;
         end
         S_EXEC: begin
            busy       = 1'b1;
            state_next = S_WB;
         end
         S_WB: begin
            busy     = 1'b1;
            reg_we_o = dec_reg_we & ~is_halt;
            mem_we_o = dec_mem_we & ~is_halt;
            if (is_halt || steps_inc == MAX_STEPS) begin
               state_next = S_DONE;
            end else begin
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
               state_next = S_PAUSE;
`else
               state_next = S_FETCH;
`endif
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) state_next = S_FETCH;
         end
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
         S_PAUSE: begin
            busy = 1'b1;
            if (step) state_next = S_FETCH;
         end
`endif
         default: state_next = S_IDLE;
      endcase
   end

   assign imem_addr = pc_reg;
   assign pc        = pc_reg;
   assign op        = op_reg;
   assign zf        = zf_reg;
   assign steps     = steps_reg;
   assign timeout   = timeout_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of per-instruction vectors plus hand sequences
// for mid-fetch reset and step-budget timeout (second instance with a budget of 4).
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        start2 = 1'b0;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_data = 16'h0;
   logic        alu_zf = 1'b0;
   logic [5:0]  dec_pc_in = 6'd0;
   logic        dec_pc_we = 1'b0;
   logic        dec_reg_we = 1'b0;
   logic        dec_mem_we = 1'b0;

   logic        busy, done, timeout, imem_req, zf, reg_we_o, mem_we_o;
   logic [5:0]  imem_addr, pc;
   logic [15:0] op, steps;

   logic        busy2, done2, timeout2, imem_req2, zf2, reg_we2, mem_we2;
   logic [5:0]  imem_addr2, pc2;
   logic [15:0] op2, steps2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.PC_W(6), .HALT_OP(5'b11111), .MAX_STEPS(16'hFFFF)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .busy(busy), .done(done), .timeout(timeout),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .op(op), .zf(zf), .alu_zf(alu_zf),
      .dec_pc_in(dec_pc_in), .dec_pc_we(dec_pc_we), .dec_reg_we(dec_reg_we), .dec_mem_we(dec_mem_we),
      .reg_we_o(reg_we_o), .mem_we_o(mem_we_o), .pc(pc), .steps(steps)
   );

   pc_sequencer #(.PC_W(6), .HALT_OP(5'b11111), .MAX_STEPS(16'd4)) u_to (
      .clk(clk), .rst_n(rst_n), .start(start2),
      .busy(busy2), .done(done2), .timeout(timeout2),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack), .imem_data(imem_data),
      .op(op2), .zf(zf2), .alu_zf(alu_zf),
      .dec_pc_in(dec_pc_in), .dec_pc_we(dec_pc_we), .dec_reg_we(dec_reg_we), .dec_mem_we(dec_mem_we),
      .reg_we_o(reg_we2), .mem_we_o(mem_we2), .pc(pc2), .steps(steps2)
   );

   typedef struct {
      logic        do_start;
      logic [15:0] word;
      int          delay;
      logic        alu;
      logic        pc_we;
      logic        jnz;
      logic [5:0]  target;
      logic        reg_we;
      logic        mem_we;
      logic [5:0]  exp_addr;
      logic        exp_zf;
      logic        exp_reg_we;
      logic        exp_mem_we;
      logic [5:0]  exp_pc;
      logic [15:0] exp_steps;
      logic        exp_done;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      int n;
      logic [15:0] old_op;
      v = vecs[i];
      if (v.do_start) begin
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
      end
      n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk); n++;
      end
      check("req_seen", {31'd0, imem_req}, 32'd1);
      check("imem_addr", {26'd0, imem_addr}, {26'd0, v.exp_addr});
      alu_zf     = v.alu;
      dec_pc_we  = v.pc_we;
      dec_pc_in  = v.target;
      dec_reg_we = v.reg_we;
      dec_mem_we = v.mem_we;
      old_op     = op;
      for (int d = 0; d < v.delay; d++) begin
         check("req_hold", {31'd0, imem_req}, 32'd1);
         check("addr_hold", {26'd0, imem_addr}, {26'd0, v.exp_addr});
         check("op_hold", {16'd0, op}, {16'd0, old_op});
         @(negedge clk);
      end
      imem_ack  = 1'b1;
      imem_data = v.word;
      @(negedge clk);
      imem_ack  = 1'b0;
      imem_data = 16'h0;
      check("op_load", {16'd0, op}, {16'd0, v.word});
      check("req_drop", {31'd0, imem_req}, 32'd0);
      check("zf_seen", {31'd0, zf}, {31'd0, v.exp_zf});
      check("strobe_dec", {30'd0, reg_we_o, mem_we_o}, 32'd0);
      if (v.jnz) dec_pc_we = zf;
      @(negedge clk);
      check("strobe_exec", {30'd0, reg_we_o, mem_we_o}, 32'd0);
      @(negedge clk);
      check("reg_we_wb", {31'd0, reg_we_o}, {31'd0, v.exp_reg_we});
      check("mem_we_wb", {31'd0, mem_we_o}, {31'd0, v.exp_mem_we});
      @(negedge clk);
      check("strobe_after", {30'd0, reg_we_o, mem_we_o}, 32'd0);
      check("pc_after", {26'd0, pc}, {26'd0, v.exp_pc});
      check("steps_after", {16'd0, steps}, {16'd0, v.exp_steps});
      check("done_after", {31'd0, done}, {31'd0, v.exp_done});
      check("next_fetch", {31'd0, imem_req}, {31'd0, ~v.exp_done});
      $display("instr %0d: addr=%0d op=%h pc=%0d steps=%0d zf=%0b done=%0b",
               i, v.exp_addr, op, pc, steps, zf, done);
   endtask

   task automatic run_to(input logic last_halt);
      int n;
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      check("to_cleared", {31'd0, timeout2}, 32'd0);
      dec_pc_we  = 1'b1;
      dec_pc_in  = 6'd0;
      dec_reg_we = 1'b0;
      dec_mem_we = 1'b0;
      alu_zf     = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!imem_req2 && n < 20) begin
            @(negedge clk); n++;
         end
         check("to_req", {31'd0, imem_req2}, 32'd1);
         check("to_addr", {26'd0, imem_addr2}, 32'd0);
         imem_ack  = 1'b1;
         imem_data = (k == 3 && last_halt) ? 16'hF800 : 16'h3000;
         @(negedge clk);
         imem_ack  = 1'b0;
         imem_data = 16'h0;
         repeat (3) @(negedge clk);
         if (k < 3) check("to_not_done", {31'd0, done2}, 32'd0);
      end
      check("to_done", {31'd0, done2}, 32'd1);
      check("to_timeout", {31'd0, timeout2}, {31'd0, ~last_halt});
      check("to_steps", {16'd0, steps2}, 32'd4);
      check("to_pc", {26'd0, pc2}, 32'd0);
      $display("budget run halt_last=%0b: done=%0b timeout=%0b steps=%0d pc=%0d",
               last_halt, done2, timeout2, steps2, pc2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //            start  word     dly alu   pc_we jnz   tgt    rwe   mwe   addr   zf    erwe  emwe  pc     steps   done
      vecs[0] = '{1'b1, 16'h0800, 0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 6'd1,  16'd1, 1'b0};
      vecs[1] = '{1'b0, 16'h0800, 0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 6'd1,  1'b0, 1'b1, 1'b0, 6'd2,  16'd2, 1'b0};
      vecs[2] = '{1'b0, 16'hF800, 0, 1'b1, 1'b1, 1'b0, 6'd9,  1'b1, 1'b1, 6'd2,  1'b0, 1'b0, 1'b0, 6'd2,  16'd3, 1'b1};
      vecs[3] = '{1'b1, 16'h1234, 3, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 6'd0,  1'b0, 1'b0, 1'b1, 6'd1,  16'd1, 1'b0};
      vecs[4] = '{1'b0, 16'h2000, 3, 1'b0, 1'b0, 1'b1, 6'd5,  1'b0, 1'b0, 6'd1,  1'b1, 1'b0, 1'b0, 6'd5,  16'd2, 1'b0};
      vecs[5] = '{1'b0, 16'h0800, 3, 1'b0, 1'b1, 1'b0, 6'd63, 1'b1, 1'b0, 6'd5,  1'b0, 1'b1, 1'b0, 6'd63, 16'd3, 1'b0};
      vecs[6] = '{1'b0, 16'h0800, 1, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 6'd63, 1'b0, 1'b1, 1'b0, 6'd0,  16'd4, 1'b0};
      vecs[7] = '{1'b0, 16'hF800, 0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'd0,  16'd5, 1'b1};
      vecs[8] = '{1'b1, 16'h0800, 0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 6'd1,  16'd1, 1'b0};
      vecs[9] = '{1'b0, 16'hF800, 0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 6'd1,  1'b0, 1'b0, 1'b0, 6'd1,  16'd2, 1'b1};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_outputs", {25'd0, busy, done, timeout, imem_req, zf, reg_we_o, mem_we_o}, 32'd0);
      check("rst_pc_steps", {10'd0, pc, steps}, 32'd0);
      check("rst_op", {16'd0, op}, 32'd0);
      $display("reset: busy=%0b done=%0b pc=%0d steps=%0d op=%h", busy, done, pc, steps, op);

      for (int i = 0; i < 8; i++) run_vec(i);

      // Reset in the middle of a fetch, then a late ack that must be ignored.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("mid_req", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_req", {31'd0, imem_req}, 32'd0);
      check("mid_rst_flags", {29'd0, busy, done, zf}, 32'd0);
      check("mid_rst_pc", {26'd0, pc}, 32'd0);
      check("mid_rst_op", {16'd0, op}, 32'd0);
      check("mid_rst_steps", {16'd0, steps}, 32'd0);
      rst_n     = 1'b1;
      imem_ack  = 1'b1;
      imem_data = 16'h0800;
      @(negedge clk);
      imem_ack  = 1'b0;
      imem_data = 16'h0;
      check("late_ack_op", {16'd0, op}, 32'd0);
      check("late_ack_busy", {30'd0, busy, imem_req}, 32'd0);
      $display("mid-fetch reset: busy=%0b req=%0b op=%h pc=%0d", busy, imem_req, op, pc);

      for (int i = 8; i < 10; i++) run_vec(i);

      run_to(1'b0);
      run_to(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
